// File: rtl/uart_report_pkg.sv
// uart_report_pkg: shared types and constants for the UART status reporter.
// State enum, message lengths, ASCII constants and the power-on banner ROM.
package uart_report_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BANNER,
    LINE,
    WAIT_BUSY,
    WAIT_IDLE,
    NEXT
  } state_e;

  localparam int BANNER_LEN = 16;
  localparam int LINE_LEN   = 13;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_P  = 8'h50;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;

  // "MEGAphone CTL0\r\n"
  function automatic logic [7:0] banner_char(input logic [3:0] idx);
    logic [7:0] c;
    case (idx)
      4'd0:    c = 8'h4D;
      4'd1:    c = 8'h45;
      4'd2:    c = 8'h47;
      4'd3:    c = 8'h41;
      4'd4:    c = 8'h70;
      4'd5:    c = 8'h68;
      4'd6:    c = 8'h6F;
      4'd7:    c = 8'h6E;
      4'd8:    c = 8'h65;
      4'd9:    c = 8'h20;
      4'd10:   c = 8'h43;
      4'd11:   c = 8'h54;
      4'd12:   c = 8'h4C;
      4'd13:   c = 8'h30;
      4'd14:   c = ASCII_CR;
      default: c = ASCII_LF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/nibble_to_hex_ascii.sv
// nibble_to_hex_ascii: one 4-bit value to its uppercase ASCII hex digit.
module nibble_to_hex_ascii
  import uart_report_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  // 0-9 map onto '0'..'9'; 10-15 skip the punctuation gap to 'A'..'F'.
  always_comb begin
    if (nibble_i < 4'd10) ascii_o = ASCII_0 + {4'h0, nibble_i};
    else                  ascii_o = 8'h37 + {4'h0, nibble_i};
  end

endmodule

// File: rtl/uart_status_reporter.sv
// uart_status_reporter: streams the power-on banner and "P0=xx P1=yy\r\n"
// snapshot lines into uart_tx over its DATA/SEND/READY handshake.
// Optional banner: define UART_REPORT_BANNER_EN to include the BANNER state
// and ROM; otherwise reset lands in IDLE and only snapshot lines are sent.
//
// state     | meaning
// IDLE      | nothing to send; start a line when a snapshot is pending
// BANNER    | wait for READY, then send banner char(char_idx)
// LINE      | wait for READY, then send line char(char_idx)
// WAIT_BUSY | wait for uart_tx to accept (READY low) or give up after timeout
// WAIT_IDLE | wait for uart_tx to finish the frame
// NEXT      | advance to the next character or finish the message
module uart_status_reporter
  import uart_report_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk48,
  input  logic       reset,
  input  logic       snap_valid,
  input  logic [7:0] snap_port0,
  input  logic [7:0] snap_port1,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_send,
  output logic       busy,
  output logic [7:0] drop_count,
  output logic [7:0] ack_timeouts
);

  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [3:0] LINE_LAST = 4'(LINE_LEN - 1);
`ifdef UART_REPORT_BANNER_EN
  localparam logic [3:0] BANNER_LAST = 4'(BANNER_LEN - 1);
`endif

  state_e          state_q;
  logic [3:0]      char_idx_q;
  logic [TW-1:0]   to_cnt_q;
  logic [7:0]      tx_data_q;
  logic            tx_send_q;
  logic            pend_q;
  logic [7:0]      pend_p0_q, pend_p1_q;
  logic [7:0]      line_p0_q, line_p1_q;
  logic [7:0]      drop_q, drop_d;
  logic [7:0]      ackto_q, ackto_d;
`ifdef UART_REPORT_BANNER_EN
  logic            banner_mode_q;
`endif

  logic [3:0]      nib_sel;
  logic [7:0]      hex_char;
  logic [7:0]      line_char_d;
  logic [7:0]      cur_char_d;
  logic [3:0]      last_idx;
  state_e          msg_state;
  logic            consume;

  // Pick the nibble feeding the single hex converter from the character index.
  always_comb begin
    case (char_idx_q)
      4'd3:    nib_sel = line_p0_q[7:4];
      4'd4:    nib_sel = line_p0_q[3:0];
      4'd9:    nib_sel = line_p1_q[7:4];
      4'd10:   nib_sel = line_p1_q[3:0];
      default: nib_sel = 4'h0;
    endcase
  end

  nibble_to_hex_ascii u_hex (
    .nibble_i (nib_sel),
    .ascii_o  (hex_char)
  );

  // Snapshot line character at char_idx.
  always_comb begin
    case (char_idx_q)
      4'd0, 4'd6:              line_char_d = ASCII_P;
      4'd1:                    line_char_d = ASCII_0;
      4'd7:                    line_char_d = ASCII_1;
      4'd2, 4'd8:              line_char_d = ASCII_EQ;
      4'd3, 4'd4, 4'd9, 4'd10: line_char_d = hex_char;
      4'd5:                    line_char_d = ASCII_SP;
      4'd11:                   line_char_d = ASCII_CR;
      4'd12:                   line_char_d = ASCII_LF;
      default:                 line_char_d = 8'h00;
    endcase
  end

  // Select the active message: character source, last index and send state.
  always_comb begin
`ifdef UART_REPORT_BANNER_EN
    cur_char_d = banner_mode_q ? banner_char(char_idx_q) : line_char_d;
    last_idx   = banner_mode_q ? BANNER_LAST : LINE_LAST;
    msg_state  = banner_mode_q ? BANNER : LINE;
`else
    cur_char_d = line_char_d;
    last_idx   = LINE_LAST;
    msg_state  = LINE;
`endif
  end

  // Saturating status counters. A snapshot arriving in the same cycle that IDLE
  // takes the pending one is not an overwrite, so it is not counted as a drop.
  always_comb begin
    consume = (state_q == IDLE) && pend_q;
    drop_d  = drop_q;
    ackto_d = ackto_q;
    if (snap_valid && pend_q && !consume && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
    if (state_q == WAIT_BUSY && tx_ready && to_cnt_q == '0 && ackto_q != 8'hFF)
      ackto_d = ackto_q + 8'd1;
  end

  // Message sequencer plus the 1-deep snapshot buffer, all state registered here.
  always_ff @(posedge clk48) begin
    if (reset) begin
`ifdef UART_REPORT_BANNER_EN
      state_q       <= BANNER;
      banner_mode_q <= 1'b1;
`else
      state_q       <= IDLE;
`endif
      char_idx_q <= 4'd0;
      to_cnt_q   <= '0;
      tx_data_q  <= 8'h00;
      tx_send_q  <= 1'b0;
      pend_q     <= 1'b0;
      pend_p0_q  <= 8'h00;
      pend_p1_q  <= 8'h00;
      line_p0_q  <= 8'h00;
      line_p1_q  <= 8'h00;
      drop_q     <= 8'h00;
      ackto_q    <= 8'h00;
    end else begin
      tx_send_q <= 1'b0;
      drop_q    <= drop_d;
      ackto_q   <= ackto_d;
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            line_p0_q  <= pend_p0_q;
            line_p1_q  <= pend_p1_q;
            pend_q     <= 1'b0;
            char_idx_q <= 4'd0;
`ifdef UART_REPORT_BANNER_EN
            banner_mode_q <= 1'b0;
`endif
            state_q    <= LINE;
          end
        end
`ifdef UART_REPORT_BANNER_EN
        BANNER,
`endif
        LINE: begin
          if (tx_ready) begin
            tx_data_q <= cur_char_d;
            tx_send_q <= 1'b1;
            to_cnt_q  <= TO_LOAD;
            state_q   <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!tx_ready)            state_q  <= WAIT_IDLE;
          else if (to_cnt_q == '0)  state_q  <= NEXT;
          else                      to_cnt_q <= to_cnt_q - 1'b1;
        end
        WAIT_IDLE: begin
          if (tx_ready) state_q <= NEXT;
        end
        NEXT: begin
          if (char_idx_q == last_idx) begin
            state_q <= IDLE;
          end else begin
            char_idx_q <= char_idx_q + 4'd1;
            state_q    <= msg_state;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Capture last so a new snapshot wins over IDLE clearing pending.
      if (snap_valid) begin
        pend_q    <= 1'b1;
        pend_p0_q <= snap_port0;
        pend_p1_q <= snap_port1;
      end
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_send      = tx_send_q;
  assign busy         = (state_q != IDLE);
  assign drop_count   = drop_q;
  assign ack_timeouts = ackto_q;

endmodule
